// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the RV32M multiply/divide sequencer
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add multiply or restoring divide iteration
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [2*W-1:0] acc,
    input  logic [W-1:0]   operand,
    input  logic           next_bit,
    input  logic           is_div,
    output logic [2*W-1:0] acc_next
);

    // Divide: acc = {remainder, quotient}; the trial word is one bit wider
    // because a shifted remainder can exceed W bits before the subtract.
    logic [W:0]   trial;
    logic [W-1:0] diff;
    logic [W-1:0] add_term;

    always_comb begin
        trial    = {acc[2*W-1:W], next_bit};
        diff     = trial[W-1:0] - operand;
        add_term = next_bit ? operand : '0;
        acc_next = '0;
        if (is_div) begin
            if (trial >= {1'b0, operand}) begin
                acc_next = {diff, acc[W-2:0], 1'b1};
            end else begin
                acc_next = {trial[W-1:0], acc[W-2:0], 1'b0};
            end
        end else begin
            acc_next = {acc[2*W-2:0], 1'b0} + {{W{1'b0}}, add_term};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide unit with pipeline stall
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = muldiv_pkg::XLEN,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t              state, state_nxt;
    logic [2:0]          op;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                neg_q, neg_r;
    logic [2*XLEN-1:0]   acc, acc_step;
    logic [CNT_W-1:0]    cnt, bit_idx;
    logic                accept, fast, div0, ovf;
    logic                signed_a, signed_b, sa, sb;
    logic [XLEN-1:0]     fast_val, fix_val;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rem;
    logic                last_step;

    assign accept    = (state == S_IDLE) && start && !flush;
    assign last_step = (cnt == CNT_W'(XLEN - 1));
    assign bit_idx   = CNT_W'(XLEN - 1) - cnt;

    assign signed_a = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
    assign signed_b = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                      (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign sa       = signed_a && srcA[XLEN-1];
    assign sb       = signed_b && srcB[XLEN-1];

    // Divide-by-zero and signed overflow resolve without iterating.
    assign div0     = funct3[2] && (srcB == '0);
    assign ovf      = funct3[2] && !funct3[0] &&
                      (srcA == {1'b1, {(XLEN-1){1'b0}}}) && (srcB == '1);
    assign fast     = div0 || ovf;
    assign fast_val = div0 ? (funct3[1] ? srcA : '1) : (funct3[1] ? '0 : srcA);

    muldiv_step #(.W(XLEN)) u_step (
        .acc      (acc),
        .operand  (op[2] ? mag_b : mag_a),
        .next_bit (op[2] ? mag_a[bit_idx] : mag_b[bit_idx]),
        .is_div   (op[2]),
        .acc_next (acc_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = fast ? S_DONE : S_CALC;
            S_CALC:  if (flush) state_nxt = S_IDLE;
                     else if (last_step) state_nxt = S_FIX;
            S_FIX:   state_nxt = flush ? S_IDLE : S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == S_CALC) || (state == S_FIX);
        done  = (state == S_DONE) && !flush;
        stall = start || busy;
    end

    // Quotient and product share neg_q; the remainder follows the dividend.
    always_comb begin
        prod    = neg_q ? -acc : acc;
        quo     = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem     = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fix_val = '0;
        unique case (op)
            F3_MUL:                       fix_val = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_val = quo;
            default:                      fix_val = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op     <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (accept) begin
            op    <= funct3;
            mag_a <= sa ? -srcA : srcA;
            mag_b <= sb ? -srcB : srcB;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            acc   <= '0;
            cnt   <= '0;
            if (fast) begin
                result <= fast_val;
            end
        end else if (state == S_CALC) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
        end else if (state == S_FIX && !flush) begin
            result <= fix_val;
        end
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative RV32M multiply/divide unit for the execute stage, alongside the single-cycle ALU. It accepts one operation at a time, decoded from `funct3` of an OP instruction with funct7 = 0000001. It sequences a 32-step shift-add multiply or restoring divide, and holds the pipeline stalled until the result is valid.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; only 32 is supported.
- `CNT_W`, 5: iteration counter width, equal to $clog2(XLEN).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; accepted only in IDLE.
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `srcA`  in  XLEN  rs1 operand (multiplicand/dividend).
- `srcB`  in  XLEN  rs2 operand (multiplier/divisor).
- `flush`  in  1  abort the current operation (branch taken/trap).
- `busy`  out  1  operation in progress (CALC or FIX).
- `stall`  out  1  equals `start | busy`; holds the pipeline front-end.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  XLEN  final value; held until the next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1, normal case:
  - Latch `funct3`.
  - Latch operand magnitudes. Signed operands are |x|. MULHSU treats srcB as unsigned.
  - Latch result-sign flags.
  - Clear the 64-bit accumulator and the counter.
  - Go to CALC.
- IDLE, start=1, fast path: go directly to DONE, with no CALC.
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give srcA.
  - Signed overflow (DIV/REM with srcA=0x80000000, srcB=0xFFFFFFFF): quotient 0x80000000, remainder 0.
- CALC, one step per cycle; counter increments and goes to FIX when counter == XLEN-1.
  - Multiply: shift-add one multiplier bit.
  - Divide: restoring subtract-shift for one quotient bit.
- FIX, one cycle:
  - Negate the result if its sign flag is set. The quotient sign is signA^signB; the remainder sign is signA.
  - Select the word: low product (MUL), high product (MULH*), quotient or remainder.
  - Register `result`, then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE. A start in DONE is ignored; the pipeline is still stalled, so it re-presents start in the next cycle.
- start while busy is ignored; latched operands are not disturbed.
- flush in CALC/FIX/DONE → IDLE next cycle, no `done` pulse, `result` unchanged. flush in IDLE is a no-op, and a simultaneous start is dropped.
- rst has priority over flush and start.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=0, counter=0.
- Accept edge is cycle 0.
  - Normal path: CALC in cycles 1–32, FIX in cycle 33, `done`=1 in cycle 34.
  - Fast path: `done`=1 in cycle 1.
- `busy` rises in the cycle after accept and falls on entry to DONE.
- `stall` is combinational from `start`, so the requesting instruction is held in its accept cycle.
- Back-to-back: the earliest next accept is the cycle after DONE. Issue-to-issue is 35 cycles on the normal path and 2 cycles on the fast path.
- `result` changes only on the FIX edge or the fast-path accept edge.

## Structure
- Package `muldiv_pkg`:
  - `typedef enum logic [1:0]` for the state.
  - localparams for the eight funct3 codes.
  - localparam XLEN.
- Sub-module `muldiv_step` (combinational):
  - Inputs: accumulator, operand, mode.
  - Outputs: next accumulator after one multiply or divide iteration.
  - Keeps the FSM and registers in the top level.

## Test plan
- MUL 7 × 0xFFFFFFFD → `result`=0xFFFFFFEB; `done` in cycle 34; `busy` high in cycles 1–33.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM 0xFFFFFFF9 % 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14.
- DIVU 5 / 0 → 0xFFFFFFFF and REMU 5 % 0 → 5, both with `done` in cycle 1; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 with `done` in cycle 1.
- Start MUL 3 × 4:
  - Pulse start with different operands in cycle 5 → ignored; result=12 in cycle 34.
  - Repeat the run with flush in cycle 10 → IDLE in cycle 11, no `done`, result still 12.
  - A new start in cycle 12 is accepted.
- rst asserted in cycle 5 of a DIV → state IDLE, `busy`=0, `result`=0 from cycle 6; no `done` pulse follows.
